mat_loader: RTL and testbench

MAT_LOADER -- requirements
Module: mat_loader

---
 rtl/matmul_pkg.sv | 29 ++
 rtl/mat_loader_if.sv | 29 ++
 rtl/mat_buf_writer.sv | 31 +++
 rtl/mat_loader.sv | 141 ++++++++++++++
 tb/tb_mat_loader.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// Shared types and sizing for the matrix loader and the matmul datapath.
package matmul_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned M          = 32;

  localparam int unsigned IdxWidth  = $clog2(M);
  localparam int unsigned DimWidth  = IdxWidth + 1;
  localparam int unsigned ElemWidth = 2 * DATA_WIDTH + IdxWidth;

  typedef logic signed [DATA_WIDTH-1:0] data_t;
  typedef logic signed [ElemWidth-1:0]  mat_elem_t;
  typedef logic        [DimWidth-1:0]   dim_t;
  typedef logic        [IdxWidth-1:0]   idx_t;

  typedef enum logic [1:0] {StIdle, StLoadA, StLoadB, StHold} state_e;

  localparam dim_t MaxDim = dim_t'(M);

  function automatic logic dim_ok(dim_t d);
    return (d != '0) && (d <= MaxDim);
  endfunction

  // True when idx is the last position of a dimension of size d.
  function automatic logic is_last(idx_t idx, dim_t d);
    return {1'b0, idx} == (d - dim_t'(1));
  endfunction

endpackage

// File: rtl/mat_loader_if.sv
// Command, element stream and operand buses between the loader and its neighbours.
interface mat_loader_if;
  import matmul_pkg::*;

  logic      cfg_valid;
  logic      cfg_ready;
  dim_t      cfg_rows;
  dim_t      cfg_cols;
  dim_t      cfg_cols2;
  logic      cfg_err;
  logic      in_valid;
  logic      in_ready;
  data_t     in_data;
  mat_elem_t mat1 [M][M];
  mat_elem_t mat2 [M][M];
  logic      mat_valid;
  logic      mat_ack;

  modport slave (
    input  cfg_valid, cfg_rows, cfg_cols, cfg_cols2, in_valid, in_data, mat_ack,
    output cfg_ready, cfg_err, in_ready, mat1, mat2, mat_valid
  );

  modport master (
    output cfg_valid, cfg_rows, cfg_cols, cfg_cols2, in_valid, in_data, mat_ack,
    input  cfg_ready, cfg_err, in_ready, mat1, mat2, mat_valid
  );

endinterface

// File: rtl/mat_buf_writer.sv
// One M x M operand buffer with bulk clear and single-element indexed write.
module mat_buf_writer import matmul_pkg::*; (
  input  logic      clk,
  input  logic      reset,
  input  logic      clr,
  input  logic      we,
  input  idx_t      row,
  input  idx_t      col,
  input  mat_elem_t wdata,
  output mat_elem_t mem [M][M]
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < M; r++) begin
        for (int unsigned c = 0; c < M; c++) begin
          mem[r][c] <= '0;
        end
      end
    end else if (clr) begin
      for (int unsigned r = 0; r < M; r++) begin
        for (int unsigned c = 0; c < M; c++) begin
          mem[r][c] <= '0;
        end
      end
    end else if (we) begin
      mem[row][col] <= wdata;
    end
  end

endmodule

// File: rtl/mat_loader.sv
// Accepts a dimension command, streams A then B row-major into two buffers,
// and holds them for the consumer until acknowledged.
module mat_loader import matmul_pkg::*; (
  input logic         clk,
  input logic         reset,
  mat_loader_if.slave bus
);

  state_e    state_q, state_d;
  idx_t      i_q, i_d, j_q, j_d;
  dim_t      rows_q, rows_d, cols_q, cols_d, cols2_q, cols2_d;
  logic      err_q, err_d;
  logic      clr, we_a, we_b;
  logic      cfg_ready;
  mat_elem_t wdata;
  mat_elem_t buf_a [M][M];
  mat_elem_t buf_b [M][M];

  // Gated by reset so the command port is closed while reset is held.
  assign cfg_ready     = reset && (state_q == StIdle);
  assign bus.cfg_ready = cfg_ready;
  assign bus.in_ready  = (state_q == StLoadA) || (state_q == StLoadB);
  assign bus.mat_valid = (state_q == StHold);
  assign bus.cfg_err   = err_q;
  assign wdata         = mat_elem_t'(bus.in_data);

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    cols2_d = cols2_q;
    err_d   = 1'b0;
    clr     = 1'b0;
    we_a    = 1'b0;
    we_b    = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.cfg_valid && cfg_ready) begin
          if (dim_ok(bus.cfg_rows) && dim_ok(bus.cfg_cols) && dim_ok(bus.cfg_cols2)) begin
            rows_d  = bus.cfg_rows;
            cols_d  = bus.cfg_cols;
            cols2_d = bus.cfg_cols2;
            i_d     = '0;
            j_d     = '0;
            clr     = 1'b1;
            state_d = StLoadA;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoadA: begin
        if (bus.in_valid) begin
          we_a = 1'b1;
          if (is_last(j_q, cols_q)) begin
            j_d = '0;
            if (is_last(i_q, rows_q)) begin
              i_d     = '0;
              state_d = StLoadB;
            end else begin
              i_d = i_q + idx_t'(1);
            end
          end else begin
            j_d = j_q + idx_t'(1);
          end
        end
      end
      StLoadB: begin
        // B is cols x cols2.
        if (bus.in_valid) begin
          we_b = 1'b1;
          if (is_last(j_q, cols2_q)) begin
            j_d = '0;
            if (is_last(i_q, cols_q)) begin
              i_d     = '0;
              state_d = StHold;
            end else begin
              i_d = i_q + idx_t'(1);
            end
          end else begin
            j_d = j_q + idx_t'(1);
          end
        end
      end
      StHold: begin
        if (bus.mat_ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      cols2_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      cols2_q <= cols2_d;
      err_q   <= err_d;
    end
  end

  mat_buf_writer u_buf_a (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .we    (we_a),
    .row   (i_q),
    .col   (j_q),
    .wdata (wdata),
    .mem   (buf_a)
  );

  mat_buf_writer u_buf_b (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .we    (we_b),
    .row   (i_q),
    .col   (j_q),
    .wdata (wdata),
    .mem   (buf_b)
  );

  assign bus.mat1 = buf_a;
  assign bus.mat2 = buf_b;

endmodule

// File: tb/tb_mat_loader.sv
// Randomised bench for mat_loader against a row-major array model of both operands.
module tb_mat_loader;
  import matmul_pkg::*;

  localparam int MI = M;

  logic clk;
  logic reset;
  mat_loader_if bus ();

  mat_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int     n_tests;
  int     n_fail;
  longint exp1 [MI][MI];
  longint exp2 [MI][MI];
  longint stim [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint want);
    n_tests++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, want);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < MI; r++) begin
      for (int c = 0; c < MI; c++) begin
        exp1[r][c] = 0;
        exp2[r][c] = 0;
      end
    end
  endtask

  task automatic compare_bufs(input string tag);
    int bad1 = 0;
    int bad2 = 0;
    for (int r = 0; r < MI; r++) begin
      for (int c = 0; c < MI; c++) begin
        if (longint'(bus.mat1[r][c]) != exp1[r][c]) bad1++;
        if (longint'(bus.mat2[r][c]) != exp2[r][c]) bad2++;
      end
    end
    check({tag, "_mat1_bad"}, bad1, 0);
    check({tag, "_mat2_bad"}, bad2, 0);
  endtask

  task automatic send_cmd(input int r, input int c, input int c2);
    bit ok;
    ok = (r >= 1) && (r <= MI) && (c >= 1) && (c <= MI) && (c2 >= 1) && (c2 <= MI);
    bus.cfg_valid = 1'b1;
    bus.cfg_rows  = dim_t'(r);
    bus.cfg_cols  = dim_t'(c);
    bus.cfg_cols2 = dim_t'(c2);
    check("cfg_ready_idle", bus.cfg_ready, 1);
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    check("cfg_err_next", bus.cfg_err, ok ? 0 : 1);
    if (ok) begin
      model_clear();
      check("in_ready_after_cmd", bus.in_ready, 1);
    end else begin
      check("cfg_ready_after_rej", bus.cfg_ready, 1);
      @(posedge clk); #1;
      check("cfg_err_one_pulse", bus.cfg_err, 0);
    end
  endtask

  // mode 0: continuous, 1: valid every other cycle, 2: as 1 plus command noise.
  task automatic run_load(input int r, input int c, input int c2, input int mode);
    int total = r * c + c * c2;
    int k = 0;
    int cyc = 0;
    int bad_rdy = 0;
    int bad_mv = 0;
    int err_seen = 0;
    bit vld;
    while (k < total && cyc < 20000) begin
      vld = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      bus.in_valid = vld;
      bus.in_data  = data_t'(stim[k]);
      if (mode == 2) begin
        bus.cfg_valid = 1'($urandom_range(0, 1));
        bus.cfg_rows  = dim_t'($urandom_range(0, 63));
        bus.cfg_cols  = dim_t'($urandom_range(0, 63));
        bus.cfg_cols2 = dim_t'($urandom_range(0, 63));
      end
      if (bus.in_ready !== 1'b1) bad_rdy++;
      if (bus.mat_valid !== 1'b0) bad_mv++;
      @(posedge clk); #1;
      if (bus.cfg_err !== 1'b0) err_seen++;
      if (vld) k++;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.cfg_valid = 1'b0;
    check("beats_accepted", k, total);
    check("in_ready_during_load_bad", bad_rdy, 0);
    check("mat_valid_early", bad_mv, 0);
    check("cfg_err_during_load", err_seen, 0);
    check("mat_valid_after_last", bus.mat_valid, 1);
    check("in_ready_in_hold", bus.in_ready, 0);
    for (int n = 0; n < r * c; n++) exp1[n / c][n % c] = stim[n];
    for (int n = 0; n < c * c2; n++) exp2[n / c2][n % c2] = stim[r * c + n];
  endtask

  task automatic hold_probe();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sh1234;
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("hold_mat_valid", bus.mat_valid, 1);
    check("hold_in_ready", bus.in_ready, 0);
  endtask

  task automatic do_ack();
    bus.mat_ack = 1'b1;
    @(posedge clk); #1;
    bus.mat_ack = 1'b0;
    check("ack_mat_valid", bus.mat_valid, 0);
    check("ack_cfg_ready", bus.cfg_ready, 1);
  endtask

  task automatic fill_rand(input int n, input int lo, input int hi);
    stim.delete();
    for (int x = 0; x < n; x++) stim.push_back(longint'($urandom_range(hi - lo, 0)) + lo);
  endtask

  initial begin
    logic [ElemWidth-1:0] raw;
    n_tests       = 0;
    n_fail        = 0;
    reset         = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_rows  = '0;
    bus.cfg_cols  = '0;
    bus.cfg_cols2 = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.mat_ack   = 1'b0;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    check("rst_cfg_ready", bus.cfg_ready, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_mat_valid", bus.mat_valid, 0);
    check("rst_cfg_err", bus.cfg_err, 0);
    compare_bufs("rst");
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_cfg_ready", bus.cfg_ready, 1);

    // Scenario 1: 2x3 * 3x2 fixed data.
    stim.delete();
    for (int x = 1; x <= 6; x++) stim.push_back(x);
    for (int x = 1; x <= 6; x++) stim.push_back(-x);
    send_cmd(2, 3, 2);
    run_load(2, 3, 2, 0);
    check("s1_mat1_1_2", bus.mat1[1][2], 6);
    check("s1_mat2_2_1", bus.mat2[2][1], -6);
    check("s1_mat1_2_0", bus.mat1[2][0], 0);
    compare_bufs("s1");
    hold_probe();
    compare_bufs("s1_hold");
    do_ack();

    // Scenario 2: rejected commands leave everything alone.
    send_cmd(2, 0, 2);
    send_cmd(33, 2, 2);
    check("s2_in_ready", bus.in_ready, 0);
    compare_bufs("s2");

    // Scenario 4: most negative input sign-extends across the full element.
    stim.delete();
    stim.push_back(-32768);
    stim.push_back(-32768);
    send_cmd(1, 1, 1);
    run_load(1, 1, 1, 0);
    raw = bus.mat1[0][0];
    check("s4_raw_bits", longint'(raw), longint'(37'h1F_FFFF_8000));
    check("s4_value", bus.mat2[0][0], -32768);
    compare_bufs("s4");
    do_ack();

    // Scenario 3: full size, gapped stream, command noise during load.
    fill_rand(2 * MI * MI, 0, 3);
    send_cmd(MI, MI, MI);
    run_load(MI, MI, MI, 2);
    compare_bufs("s3");
    do_ack();

    // Scenario 5: reset in the middle of a 4x4 load.
    fill_rand(32, -32768, 32767);
    send_cmd(4, 4, 4);
    bus.in_valid = 1'b1;
    for (int x = 0; x < 5; x++) begin
      bus.in_data = data_t'(stim[x]);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    model_clear();
    #2;
    check("s5_mat_valid", bus.mat_valid, 0);
    check("s5_in_ready", bus.in_ready, 0);
    check("s5_cfg_ready", bus.cfg_ready, 0);
    compare_bufs("s5_rst");
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("s5_no_beats", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    compare_bufs("s5_after");
    fill_rand(2, -32768, 32767);
    send_cmd(1, 1, 1);
    run_load(1, 1, 1, 0);
    compare_bufs("s5_1x1");

    // Scenario 6: ack and a new command presented together.
    do_ack();
    fill_rand(8, -32768, 32767);
    send_cmd(2, 2, 2);
    run_load(2, 2, 2, 1);
    bus.mat_ack   = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.cfg_rows  = dim_t'(3);
    bus.cfg_cols  = dim_t'(3);
    bus.cfg_cols2 = dim_t'(3);
    check("s6_ready_in_hold", bus.cfg_ready, 0);
    @(posedge clk); #1;
    bus.mat_ack = 1'b0;
    check("s6_mat_valid", bus.mat_valid, 0);
    check("s6_cfg_ready", bus.cfg_ready, 1);
    check("s6_in_ready_idle", bus.in_ready, 0);
    compare_bufs("s6_idle");
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    check("s6_in_ready_load", bus.in_ready, 1);
    model_clear();
    compare_bufs("s6_clr");
    fill_rand(18, -32768, 32767);
    run_load(3, 3, 3, 0);
    compare_bufs("s6_3x3");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
